// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Shares a 16-bit SRAM between IF and MEM. Each word is moved as
//            two half-word phases. MEM has priority. Drives pipeline freeze.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int LEN         = 32,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [LEN-1:0]    if_addr,
    output logic [LEN-1:0]    if_rdata,
    output logic              if_ready,
    input  logic              mem_read_req,
    input  logic              mem_write_req,
    input  logic [LEN-1:0]    mem_addr,
    input  logic [LEN-1:0]    mem_wdata,
    output logic [LEN-1:0]    mem_rdata,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              freeze_pipe
);

    localparam int c_CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_wait;
    logic                r_owner_mem;
    logic                r_is_write;
    logic [ADDR_W-2:0]   r_addr;
    logic [15:0]         r_wdata_hi;
    logic [15:0]         r_rd_lo;
    logic                w_last;
    logic                w_unused;

    assign w_last = (r_wait == c_LAST);

    // Freeze is combinational so a ready pulse releases the pipe in the same cycle.
    assign freeze_pipe = (if_req & ~if_ready) | ((mem_read_req | mem_write_req) & ~mem_ready);

    assign w_unused = &{1'b0, if_addr[LEN-1:ADDR_W+1], if_addr[1:0],
                        mem_addr[LEN-1:ADDR_W+1], mem_addr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_owner_mem <= 1'b0;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata_hi  <= '0;
            r_rd_lo     <= '0;
            if_rdata    <= '0;
            if_ready    <= 1'b0;
            mem_rdata   <= '0;
            mem_ready   <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wait    <= '0;
                    sram_we_n <= 1'b1;
                    // A simultaneous read+write from MEM performs only the write.
                    if (mem_read_req || mem_write_req) begin
                        r_state     <= S_LO;
                        r_owner_mem <= 1'b1;
                        r_is_write  <= mem_write_req;
                        r_addr      <= mem_addr[ADDR_W:2];
                        r_wdata_hi  <= mem_wdata[31:16];
                        sram_addr   <= {mem_addr[ADDR_W:2], 1'b0};
                        sram_dq_out <= mem_wdata[15:0];
                        sram_dq_oe  <= mem_write_req;
                    end else if (if_req) begin
                        r_state     <= S_LO;
                        r_owner_mem <= 1'b0;
                        r_is_write  <= 1'b0;
                        r_addr      <= if_addr[ADDR_W:2];
                        sram_addr   <= {if_addr[ADDR_W:2], 1'b0};
                        sram_dq_out <= '0;
                        sram_dq_oe  <= 1'b0;
                    end
                end
                S_LO: begin
                    if (w_last) begin
                        r_state     <= S_HI;
                        r_wait      <= '0;
                        r_rd_lo     <= sram_dq_in;
                        sram_addr   <= {r_addr, 1'b1};
                        sram_dq_out <= r_wdata_hi;
                        sram_we_n   <= 1'b1;
                    end else begin
                        r_wait    <= r_wait + 1'b1;
                        sram_we_n <= ~r_is_write;
                    end
                end
                S_HI: begin
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_wait      <= '0;
                        sram_addr   <= '0;
                        sram_dq_out <= '0;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                        if (r_owner_mem) begin
                            mem_ready <= 1'b1;
                            if (!r_is_write) begin
                                mem_rdata <= LEN'({sram_dq_in, r_rd_lo});
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= LEN'({sram_dq_in, r_rd_lo});
                        end
                    end else begin
                        r_wait    <= r_wait + 1'b1;
                        sram_we_n <= ~r_is_write;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed vector table plus hand-written
// sequences for reset, arbitration and reset-abort behaviour.
`default_nettype none

module tb_sram_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        freeze_pipe;

    sram_port_arbiter #(.LEN(32), .ADDR_W(18), .WAIT_CYCLES(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ready     (if_ready),
        .mem_read_req (mem_read_req),
        .mem_write_req(mem_write_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .sram_addr    (sram_addr),
        .sram_dq_out  (sram_dq_out),
        .sram_dq_in   (sram_dq_in),
        .sram_dq_oe   (sram_dq_oe),
        .sram_we_n    (sram_we_n),
        .freeze_pipe  (freeze_pipe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural SRAM: asynchronous read, write on a clock edge while strobed.
    logic [15:0] sram [0:(1<<18)-1];
    assign sram_dq_in = sram[sram_addr];

    initial begin
        forever begin
            @(posedge clock);
            if (!sram_we_n && sram_dq_oe) sram[sram_addr] = sram_dq_out;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        bit          is_mem;
        bit          is_wr;
        bit          rd_too;
        bit          preload;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] lo_a;
        logic [15:0] init_lo;
        logic [15:0] init_hi;
        logic [31:0] exp_rdata;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    function automatic vec_t mk(bit is_mem, bit is_wr, bit rd_too, bit preload,
                                logic [31:0] addr, logic [31:0] wdata, logic [17:0] lo_a,
                                logic [15:0] init_lo, logic [15:0] init_hi,
                                logic [31:0] exp_rdata, logic [15:0] exp_lo, logic [15:0] exp_hi);
        vec_t v;
        v.is_mem = is_mem; v.is_wr = is_wr; v.rd_too = rd_too; v.preload = preload;
        v.addr = addr; v.wdata = wdata; v.lo_a = lo_a;
        v.init_lo = init_lo; v.init_hi = init_hi;
        v.exp_rdata = exp_rdata; v.exp_lo = exp_lo; v.exp_hi = exp_hi;
        return v;
    endfunction

    // One transaction from an idle arbiter; sample k is taken just after grant edge + k.
    task automatic run_vec(input vec_t v, input string tag);
        logic [17:0] hi_a;
        logic [17:0] exp_a;
        logic        rdy;
        hi_a = v.lo_a + 18'd1;
        if (v.preload) begin
            sram[v.lo_a] = v.init_lo;
            sram[hi_a]   = v.init_hi;
        end
        if_req        = !v.is_mem;
        mem_read_req  = v.is_mem && (!v.is_wr || v.rd_too);
        mem_write_req = v.is_mem && v.is_wr;
        if_addr       = v.addr;
        mem_addr      = v.addr;
        mem_wdata     = v.wdata;
        for (int k = 0; k <= 4; k++) begin
            tick();
            exp_a = (k < 2) ? v.lo_a : (k < 4) ? hi_a : 18'd0;
            rdy   = v.is_mem ? mem_ready : if_ready;
            check($sformatf("%s sram_addr k=%0d", tag, k), 32'(sram_addr), 32'(exp_a));
            check($sformatf("%s ready k=%0d", tag, k), 32'(rdy), 32'(k == 4));
            check($sformatf("%s oe_we_n k=%0d", tag, k), {30'd0, sram_dq_oe, sram_we_n},
                  v.is_wr ? {30'd0, (k < 4), !(k == 1 || k == 3)} : 32'd1);
            check($sformatf("%s freeze k=%0d", tag, k), 32'(freeze_pipe), 32'(k < 4));
        end
        if (v.is_mem) check({tag, " mem_rdata"}, mem_rdata, v.exp_rdata);
        else          check({tag, " if_rdata"}, if_rdata, v.exp_rdata);
        if (v.is_wr) begin
            check({tag, " sram_lo"}, 32'(sram[v.lo_a]), 32'(v.exp_lo));
            check({tag, " sram_hi"}, 32'(sram[hi_a]), 32'(v.exp_hi));
        end
        if_req = 1'b0; mem_read_req = 1'b0; mem_write_req = 1'b0;
        tick();
    endtask

    vec_t tbl [6];

    initial begin
        int mem_at;
        int if_at;

        tbl[0] = mk(0, 0, 0, 1, 32'h10, 32'h0, 18'h08, 16'hBEEF, 16'hDEAD, 32'hDEADBEEF, 16'h0, 16'h0);
        tbl[1] = mk(1, 1, 0, 0, 32'h20, 32'h12345678, 18'h10, 16'h0, 16'h0, 32'h0, 16'h5678, 16'h1234);
        tbl[2] = mk(1, 0, 0, 0, 32'h20, 32'h0, 18'h10, 16'h0, 16'h0, 32'h12345678, 16'h0, 16'h0);
        tbl[3] = mk(1, 1, 1, 0, 32'h40, 32'hCAFEF00D, 18'h20, 16'h0, 16'h0, 32'h12345678, 16'hF00D, 16'hCAFE);
        tbl[4] = mk(0, 0, 0, 0, 32'h40, 32'h0, 18'h20, 16'h0, 16'h0, 32'hCAFEF00D, 16'h0, 16'h0);
        tbl[5] = mk(1, 0, 0, 1, 32'hFFF80047, 32'h0, 18'h22, 16'h1111, 16'h2222, 32'h22221111, 16'h0, 16'h0);

        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h10;
        mem_read_req = 1'b1; mem_write_req = 1'b0;
        mem_addr = 32'h30; mem_wdata = 32'h0;

        // Reset held with requests pending: everything stays at reset values.
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("rst sram_addr c=%0d", c), 32'(sram_addr), 32'd0);
            check($sformatf("rst oe_we_n c=%0d", c), {30'd0, sram_dq_oe, sram_we_n}, 32'd1);
            check($sformatf("rst dq_out c=%0d", c), 32'(sram_dq_out), 32'd0);
            check($sformatf("rst readys c=%0d", c), {30'd0, if_ready, mem_ready}, 32'd0);
            check($sformatf("rst if_rdata c=%0d", c), if_rdata, 32'd0);
            check($sformatf("rst mem_rdata c=%0d", c), mem_rdata, 32'd0);
            check($sformatf("rst freeze c=%0d", c), 32'(freeze_pipe), 32'd1);
        end
        reset = 1'b0;
        tick();
        check("post-reset grant mem sram_addr", 32'(sram_addr), 32'h18);
        reset = 1'b1; if_req = 1'b0; mem_read_req = 1'b0;
        tick();
        check("abort sram_addr", 32'(sram_addr), 32'd0);
        check("abort mem_ready", 32'(mem_ready), 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Same-cycle IF and MEM read: MEM first, IF after the minimum spacing.
        sram[18'h80] = 16'h3333; sram[18'h81] = 16'h4444;
        sram[18'h82] = 16'h5555; sram[18'h83] = 16'h6666;
        if_addr = 32'h104; mem_addr = 32'h100;
        if_req = 1'b1; mem_read_req = 1'b1;
        mem_at = -1; if_at = -1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            if (mem_ready) begin
                if (mem_at < 0) mem_at = k;
                mem_read_req = 1'b0;
            end
            if (if_ready) begin
                if (if_at < 0) if_at = k;
                if_req = 1'b0;
            end
        end
        check("arb mem_ready cycle", 32'(mem_at), 32'd4);
        check("arb if_ready cycle", 32'(if_at), 32'd10);
        check("arb mem_rdata", mem_rdata, 32'h44443333);
        check("arb if_rdata", if_rdata, 32'h66665555);

        // Reset during the HI phase of a write: low half lands, high half does not.
        sram[18'h30] = 16'h0000; sram[18'h31] = 16'h0BAD;
        mem_addr = 32'h60; mem_wdata = 32'hA5A55A5A; mem_write_req = 1'b1;
        repeat (3) tick();
        check("rstwr in HI sram_addr", 32'(sram_addr), 32'h31);
        reset = 1'b1; mem_write_req = 1'b0;
        tick();
        check("rstwr oe_we_n", {30'd0, sram_dq_oe, sram_we_n}, 32'd1);
        check("rstwr sram_addr", 32'(sram_addr), 32'd0);
        reset = 1'b0;
        mem_at = -1;
        for (int k = 0; k < 4; k++) begin
            if (mem_ready && mem_at < 0) mem_at = k;
            tick();
        end
        check("rstwr no mem_ready", 32'(mem_at), 32'hFFFFFFFF);
        run_vec(mk(1, 0, 0, 0, 32'h60, 32'h0, 18'h30, 16'h0, 16'h0, 32'h0BAD5A5A, 16'h0, 16'h0),
                "rstwr readback");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
